serial_adder_ctrl: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 29 ++
 rtl/full_adder_behavioral.sv | 19 +
 rtl/serial_adder_ctrl.sv | 116 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_pkg
//  Brief    : Shared constants, state type and helpers for serial_adder_ctrl
//  Revision : 1.0
// ============================================================================
package serial_adder_pkg;

  // Default operand/result width
  localparam int DEFAULT_WIDTH = 8;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT,
    S_DONE  = ST_DONE
  } state_t;

  // Bit counter width; the counter stops at width-1, so it never wraps
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder_behavioral.sv
`default_nettype none
// ============================================================================
//  Module   : full_adder_behavioral
//  Brief    : One-bit full adder cell (sum and carry-out of a + b + cin)
//  Revision : 1.0
// ============================================================================
module full_adder_behavioral (
  input  logic a,
  input  logic b,
  input  logic input_carry,
  output logic sum,
  output logic output_carry
);

  assign sum          = a ^ b ^ input_carry;
  assign output_carry = (a & b) | (input_carry & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder_ctrl
//  Brief    : Bit-serial WIDTH-bit adder around a single full adder cell,
//             LSB first, with start/busy/done handshake.
//             Optional macro SERIAL_ADDER_OVF_EN adds a signed overflow flag.
//  Revision : 1.0
// ============================================================================
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sum;
  logic             w_carry_out;
  logic [WIDTH-1:0] w_result_next;

  // The single adder cell sees the current LSBs and the fed-back carry
  full_adder_behavioral u_fa (
    .a            (r_a[0]),
    .b            (r_b[0]),
    .input_carry  (r_carry),
    .sum          (w_sum),
    .output_carry (w_carry_out)
  );

  // New sum bit enters at the MSB so the LSB-first result lands aligned
  assign w_result_next = {w_sum, r_result[WIDTH-1:1]};

  // Controller FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_carry  <= cin;
            r_cnt    <= '0;
            r_result <= '0;
            busy     <= 1'b1;
            r_state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_result <= w_result_next;
          r_carry  <= w_carry_out;
          r_a      <= {1'b0, r_a[WIDTH-1:1]};
          r_b      <= {1'b0, r_b[WIDTH-1:1]};
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            // Final bit: r_carry is the carry into the MSB here
            sum_out <= w_result_next;
            cout    <= w_carry_out;
`ifdef SERIAL_ADDER_OVF_EN
            overflow <= r_carry ^ w_carry_out;
`endif
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder_ctrl
//  Brief    : Directed self-checking bench for serial_adder_ctrl (WIDTH 8 and 4)
//  Revision : 1.0
// ============================================================================
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       cin8, cin4;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf4;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .overflow(ovf8)
`endif
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum_out(sum4), .cout(cout4)
`ifdef SERIAL_ADDER_OVF_EN
    , .overflow(ovf4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One complete 8-bit operation with latency and result checks
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [7:0] exp_sum, input logic exp_cout);
    int n;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy8}, 32'd1);
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 8);
    chk({tag, "_sum"}, {24'd0, sum8}, {24'd0, exp_sum});
    chk({tag, "_cout"}, {31'd0, cout8}, {31'd0, exp_cout});
    tick();
    chk({tag, "_done_pulse"}, {31'd0, done8}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    int ndone;
    logic [7:0] first_sum;
    logic [4:0] e4;

    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_sum",  {24'd0, sum8}, 32'd0);
    chk("rst_cout", {31'd0, cout8}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic and carry-chain additions
    run_op("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    run_op("chain_cin", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op("chain_b", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_ff01", {31'd0, ovf8}, 32'd0);
`endif
    run_op("pos_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("ovf_7f01", {31'd0, ovf8}, 32'd1);
`endif

    // Start while busy is dropped; results hold during the next operation
    a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("hold_sum_midop", {24'd0, sum8}, 32'h80);
    tick(); tick();
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0;
    first_sum = 8'hEE;
    for (int i = 0; i < 25; i++) begin
      if (done8) begin
        if (ndone == 0) first_sum = sum8;
        ndone++;
      end
      tick();
    end
    chk("busy_ignore_count", ndone, 1);
    chk("busy_ignore_sum", {24'd0, first_sum}, 32'h02);

    // Asynchronous reset part way through an operation
    a8 = 8'h35; b8 = 8'h4A; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy8}, 32'd0);
    chk("midrst_done", {31'd0, done8}, 32'd0);
    chk("midrst_sum",  {24'd0, sum8}, 32'd0);
    chk("midrst_cout", {31'd0, cout8}, 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8) ndone++;
      tick();
    end
    chk("midrst_no_done", ndone, 0);
    run_op("after_rst", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);

    // Exhaustive 4-bit sweep with start held high: one result every 6 cycles
    start4 = 1'b1;
    for (int idx = 0; idx < 512; idx++) begin
      a4 = idx[8:5]; b4 = idx[4:1]; cin4 = idx[0];
      e4 = {1'b0, a4} + {1'b0, b4} + {4'd0, cin4};
      tick();
      tick(); tick(); tick();
      if (done4 !== 1'b0) begin
        chk("exh_early_done", {31'd0, done4}, 32'd0);
      end
      tick();
      chk("exh_result", {26'd0, done4, cout4, sum4}, {26'd0, 1'b1, e4});
      tick();
    end
    start4 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
